// File: rtl/mm_controller.sv
// Sequencer for a DIM x DIM matrix multiply C = A x B: walks the i/j/k indices,
// drives the A/B/C memory addresses and the MAC datapath enables.
module mm_controller #(
    parameter int DIM        = 3,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  result_invalid,
    output logic [ADDR_WIDTH-1:0] addr_A,
    output logic [ADDR_WIDTH-1:0] addr_B,
    output logic [ADDR_WIDTH-1:0] addr_C,
    output logic                  we_C,
    output logic                  en_Mux,
    output logic                  en_PPReg,
    output logic                  en_FDReg,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // DIM never exceeds 15, so four bits hold any row/column/inner index.
    localparam logic [3:0] LAST = 4'(DIM - 1);

    state_t     state, state_next;
    logic [3:0] i, j, k;
    logic [3:0] i_next, j_next, k_next;
    logic       error_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            i     <= i_next;
            j     <= j_next;
            k     <= k_next;
            error <= error_next;
        end
    end

    always_comb begin
        state_next = state;
        i_next     = i;
        j_next     = j;
        k_next     = k;
        error_next = error;
        addr_A     = '0;
        addr_B     = '0;
        addr_C     = '0;
        we_C       = 1'b0;
        en_Mux     = 1'b0;
        en_PPReg   = 1'b0;
        en_FDReg   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = MAC;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    error_next = 1'b0;
                end
            end

            // One product per cycle; the first product loads the accumulator.
            MAC: begin
                addr_A   = ADDR_WIDTH'(i) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(k);
                addr_B   = ADDR_WIDTH'(k) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(j);
                en_PPReg = 1'b1;
                en_Mux   = (k != 4'd0);
                en_FDReg = (k == LAST);
                busy     = 1'b1;
                if (k == LAST) begin
                    k_next     = '0;
                    state_next = WRITE;
                end else begin
                    k_next = k + 4'd1;
                end
            end

            WRITE: begin
                addr_C = ADDR_WIDTH'(i) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(j);
                we_C   = 1'b1;
                busy   = 1'b1;
                if (result_invalid) begin
                    error_next = 1'b1;
                end
                if (j == LAST) begin
                    j_next = '0;
                    if (i == LAST) begin
                        i_next     = '0;
                        state_next = DONE;
                    end else begin
                        i_next     = i + 4'd1;
                        state_next = MAC;
                    end
                end else begin
                    j_next     = j + 4'd1;
                    state_next = MAC;
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule
